mem_stage: RTL
==============

# mem_stage

Memory-access stage of the CPU pipeline, consuming the EX/ME pipeline register outputs (`ex_*`). It performs word load/store over the system bus using a request/grant/strobe/ready handshake and detects misaligned accesses. It drives `busy` to the pipeline controller and holds the ME/WB pipeline register (`mem_*`) that feeds the write-back stage.

## Interface
- `TIMEOUT_CYCLES`, default 16: bus watchdog limit in cycles (used only with `MEM_BUS_TIMEOUT_EN`).
- `clk` in 1: system clock. All state updates on the falling edge, matching the neighbouring pipeline registers.
- `reset` in 1: asynchronous, active-low reset.
- `stall`, `flush` in 1: pipeline control for the ME/WB register.
- `ex_pc` in 30, `ex_en` in 1, `ex_br_flag` in 1: EX/ME word PC, valid bit, and branch-delay flag.
- `ex_mem_op` in 2: NOP=2'b00, LDW=2'b01, STW=2'b10; 2'b11 is treated as NOP.
- `ex_mem_wr_data` in 32: store data.
- `ex_ctrl_op` in 2, `ex_dst_addr` in 5, `ex_gpr_we_` in 1 (active-low): passed through to write-back.
- `ex_exp_code` in 3: upstream exception code (NO_EXP=3'h0, MISS_ALIGN=3'h4, BUS_ERR=3'h7).
- `ex_out` in 32: ALU result. It is the byte address for LDW/STW and the write-back value otherwise.
- `bus_req_` out 1, `bus_grnt_` in 1: bus request and grant, both active-low.
- `bus_as_` out 1, `bus_rw` out 1, `bus_addr` out 30, `bus_wr_data` out 32: access strobe (active-low), direction (1 = read), word address, write data.
- `bus_rd_data` in 32, `bus_rdy_` in 1: read data and ready (active-low).
- `busy` out 1: high while an access is pending. The controller stalls IF/ID/EX on it.
- `mem_pc` out 30, `mem_en` out 1, `mem_br_flag` out 1, `mem_ctrl_op` out 2, `mem_dst_addr` out 5, `mem_gpr_we_` out 1, `mem_exp_code` out 3, `mem_out` out 32: ME/WB register.

## Operation
- **Access qualification.** `acc = ex_en & (ex_exp_code==0) & (ex_mem_op is LDW or STW)`.
- **Misaligned access.** If `acc` and `ex_out[1:0] != 0`, the access is misaligned:
  - No bus activity.
  - ME/WB loads `mem_exp_code=3'h4`, `mem_gpr_we_=1`, `mem_ctrl_op=NOP`, `mem_out=0`.
- **Bus FSM states:**
  - IDLE: on an aligned `acc`, go to REQ.
  - REQ: drive `bus_req_=0`; on `bus_grnt_=0`, go to ACCESS.
  - ACCESS: drive `bus_req_=0`, `bus_as_=0`, `bus_addr=ex_out[31:2]`, `bus_rw=(op==LDW)`, `bus_wr_data=ex_mem_wr_data`. On `bus_rdy_=0`, go to IDLE.
- **busy.** `busy = acc & aligned & ~(state==ACCESS & bus_rdy_==0)`, combinational. `busy` is therefore already high in IDLE in the first cycle the access is presented.
- **Completion cycle** (ACCESS with `bus_rdy_=0`): the write-back value is `bus_rd_data` for LDW and 0 for STW. STW forces `mem_gpr_we_=1`.
- **Non-memory instructions** pass `ex_out` and all control fields through unchanged.
- **ME/WB register priority:** reset, then `stall` (hold), then `flush` (bubble), then load.
  - Bubble: all fields 0, except `mem_gpr_we_=1`, `mem_ctrl_op=NOP`, `mem_exp_code=NO_EXP`.
- **Upstream exceptions** (`ex_exp_code != 0`) are passed through with `mem_gpr_we_` forced to 1 and no bus access.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `bus_req_=1`, `bus_as_=1`, `bus_rw=1`, `bus_addr=0`, `bus_wr_data=0`.
  - ME/WB register = bubble with `mem_pc=0`, `mem_out=0`.
- **Bus outputs** are decoded from the FSM state (Moore); write-back data is combinational.
- **Latency:**
  - Non-memory instruction and misaligned access: 1 cycle.
  - Aligned access: at least 3 cycles (IDLE, REQ, ACCESS), plus grant and ready wait cycles.
- **Completion edge:** in the edge where `bus_rdy_=0` is sampled, the FSM enters IDLE, `busy` drops, and ME/WB loads the result.
- **Grant withdrawn in ACCESS:** ignored; the access completes.
- **flush during REQ or ACCESS:** the FSM continues to completion. The bus transaction is never abandoned mid-handshake.
- **Reset mid-access:** the FSM returns to IDLE immediately and bus strobes deassert asynchronously.

## Configuration
- **`MEM_BUS_TIMEOUT_EN` defined:**
  - A counter runs in ACCESS and clears on entry to ACCESS.
  - When it reaches `TIMEOUT_CYCLES-1` with `bus_rdy_` still 1, the FSM goes to IDLE and `busy` drops.
  - ME/WB loads `mem_exp_code=3'h7`, `mem_gpr_we_=1`, `mem_out=0`.
- **Undefined:** no counter is present and ACCESS waits indefinitely.

## Test plan
- **Reset:** assert `reset=0` mid-ACCESS -> `bus_as_=1`, `bus_req_=1` immediately; `mem_gpr_we_=1`, `mem_exp_code=0`.
- **Aligned load:** LDW at `ex_out=32'h0000_0104`, grant after 2 cycles, `bus_rdy_=0` with `bus_rd_data=32'hDEAD_BEEF` -> `bus_addr=30'h41`, `bus_rw=1`; `mem_out=32'hDEADBEEF` loaded on the ready edge; `busy` low thereafter.
- **Aligned store:** STW at `32'h200` with data `32'h1234_5678` -> `bus_rw=0`, `bus_wr_data=32'h12345678`, `mem_gpr_we_=1`.
- **Misaligned load:** LDW at `32'h103` -> no `bus_req_` activity, `busy=0`, `mem_exp_code=3'h4` after 1 edge.
- **Stall and flush:**
  - `stall=1` holds ME/WB for 3 cycles.
  - `stall=1` with `flush=1` holds.
  - `flush=1` alone yields a bubble while the FSM still completes a pending load.
- **Timeout:** with `MEM_BUS_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, hold `bus_rdy_=1` -> after 16 ACCESS cycles `mem_exp_code=3'h7`, FSM IDLE; without the macro, still in ACCESS at cycle 100.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipeline.
// Performs word loads/stores over a req/grant/strobe/ready bus, flags misaligned
// accesses and holds the ME/WB pipeline register. State updates on the falling clock
// edge to line up with the neighbouring pipeline registers.
// Optional bus watchdog: define MEM_BUS_TIMEOUT_EN to abort an ACCESS that never sees
// ready after TIMEOUT_CYCLES cycles and report a bus error.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [29:0] ex_pc,
  input  logic        ex_en,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic        busy,
  output logic [29:0] mem_pc,
  output logic        mem_en,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  localparam logic [1:0] MemOpLdw  = 2'b01;
  localparam logic [1:0] MemOpStw  = 2'b10;
  localparam logic [1:0] CtrlOpNop = 2'b00;

  localparam logic [2:0] ExpNone      = 3'h0;
  localparam logic [2:0] ExpMissAlign = 3'h4;
  localparam logic [2:0] ExpBusErr    = 3'h7;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAccess
  } state_e;

  // One ME/WB pipeline record.
  typedef struct packed {
    logic [29:0] pc;
    logic        en;
    logic        br_flag;
    logic [1:0]  ctrl_op;
    logic [4:0]  dst_addr;
    logic        gpr_we_;
    logic [2:0]  exp_code;
    logic [31:0] out;
  } mewb_t;

  // Bubble: no valid instruction, no register write, no exception.
  localparam mewb_t MewbBubble = '{
    pc:       30'h0,
    en:       1'b0,
    br_flag:  1'b0,
    ctrl_op:  CtrlOpNop,
    dst_addr: 5'h0,
    gpr_we_:  1'b1,
    exp_code: ExpNone,
    out:      32'h0
  };

  state_e state_q, state_d;
  mewb_t  mewb_q, mewb_d;

  logic is_ldw;
  logic is_stw;
  logic acc;
  logic aligned;
  logic acc_ok;
  logic misalign;
  logic done;
  logic timeout;

  // Access qualification and classification.
  always_comb begin
    is_ldw   = (ex_mem_op == MemOpLdw);
    is_stw   = (ex_mem_op == MemOpStw);
    acc      = ex_en & (ex_exp_code == ExpNone) & (is_ldw | is_stw);
    aligned  = (ex_out[1:0] == 2'b00);
    acc_ok   = acc & aligned;
    misalign = acc & ~aligned;
    done     = (state_q == StAccess) & ~bus_rdy_;
    // busy drops in the completing cycle so the pipeline advances on the same edge
    busy     = acc_ok & ~done & ~timeout;
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Watchdog counts ACCESS cycles; held at zero elsewhere so it is clear on entry.
  always_comb begin
    cnt_d   = (state_q == StAccess) ? cnt_q + CntW'(1) : '0;
    timeout = (state_q == StAccess) & bus_rdy_ & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  // Watchdog counter register.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // No watchdog: ACCESS waits for ready indefinitely. The term keeps the limit
  // parameter referenced so both builds share one interface.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Bus FSM next state; a started transaction always runs to completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (acc_ok) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (!bus_grnt_) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Grant withdrawal is ignored here; only ready (or the watchdog) ends it.
        if (done || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore decode of bus strobes from the FSM state.
  always_comb begin
    bus_req_    = 1'b1;
    bus_as_     = 1'b1;
    bus_rw      = 1'b1;
    bus_addr    = 30'h0;
    bus_wr_data = 32'h0;
    unique case (state_q)
      StReq: begin
        bus_req_ = 1'b0;
      end
      StAccess: begin
        bus_req_    = 1'b0;
        bus_as_     = 1'b0;
        bus_rw      = is_ldw;
        bus_addr    = ex_out[31:2];
        bus_wr_data = ex_mem_wr_data;
      end
      default: ;
    endcase
  end

  // ME/WB next record: hold on stall, bubble on flush, otherwise load the result.
  always_comb begin
    mewb_d = '{
      pc:       ex_pc,
      en:       ex_en,
      br_flag:  ex_br_flag,
      ctrl_op:  ex_ctrl_op,
      dst_addr: ex_dst_addr,
      gpr_we_:  ex_gpr_we_,
      exp_code: ex_exp_code,
      out:      ex_out
    };
    if (ex_en && (ex_exp_code != ExpNone)) begin
      // Upstream exception: carry it forward but never write a register.
      mewb_d.gpr_we_ = 1'b1;
    end else if (misalign) begin
      mewb_d.exp_code = ExpMissAlign;
      mewb_d.gpr_we_  = 1'b1;
      mewb_d.ctrl_op  = CtrlOpNop;
      mewb_d.out      = 32'h0;
    end else if (acc_ok) begin
      if (done) begin
        mewb_d.out = is_ldw ? bus_rd_data : 32'h0;
        if (is_stw) begin
          mewb_d.gpr_we_ = 1'b1;
        end
      end else if (timeout) begin
        mewb_d.exp_code = ExpBusErr;
        mewb_d.gpr_we_  = 1'b1;
        mewb_d.out      = 32'h0;
      end else begin
        // Access still in flight: write-back sees bubbles until it completes.
        mewb_d = MewbBubble;
      end
    end
    if (flush) begin
      mewb_d = MewbBubble;
    end
    if (stall) begin
      mewb_d = mewb_q;
    end
  end

  // FSM and ME/WB registers; reset also drops bus strobes asynchronously.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mewb_q  <= MewbBubble;
    end else begin
      state_q <= state_d;
      mewb_q  <= mewb_d;
    end
  end

  // ME/WB register fields to ports.
  always_comb begin
    mem_pc       = mewb_q.pc;
    mem_en       = mewb_q.en;
    mem_br_flag  = mewb_q.br_flag;
    mem_ctrl_op  = mewb_q.ctrl_op;
    mem_dst_addr = mewb_q.dst_addr;
    mem_gpr_we_  = mewb_q.gpr_we_;
    mem_exp_code = mewb_q.exp_code;
    mem_out      = mewb_q.out;
  end

endmodule
